pb_press_detect: RTL
====================

Name: pb_press_detect

Overview:
Companion to the push-button release synchronizer. This block handles the press side of the active-low push button: it synchronizes, debounces, and reports a clean press pulse, a held level and a long-press pulse. It sits between the raw board button and the command/tour-start logic, and runs on the 50 MHz system clock.

Parameters:
DEBOUNCE_CYC, 250000, consecutive synchronized cycles the level must hold before a press or release is accepted (5 ms); legal range >= 1
LONG_CYC, 50000000, cycles from the accepted press to long_press (1 s); legal range >= 1
REPEAT_CYC, 10000000, auto-repeat period after long_press; used only when PB_REPEAT_EN is defined; legal range >= 1

Ports:
clk  input  1  50 MHz system clock
rst_n  input  1  asynchronous active-low reset
PB  input  1  raw, unsynchronized push button; low = pressed
pressed  output  1  one-cycle pulse on an accepted press (and on auto-repeats)
held  output  1  level, high while the debounced button is pressed
long_press  output  1  one-cycle pulse when the press has lasted LONG_CYC

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. During reset, both synchronizer flops preset to 1, FSM = IDLE, all counters = 0, pressed/held/long_press = 0.
- Synchronizer: 2 flops, PB -> pb_m -> pb_s. Only pb_s feeds the FSM. All outputs are registered.
- Counters: debounce counter width $clog2(DEBOUNCE_CYC+1). Hold counter width $clog2(max(LONG_CYC,REPEAT_CYC)+1). Counters saturate and never wrap.
- FSM states and transitions:
  IDLE: pb_s=0 -> PRESS_DB with dbcnt=1.
  PRESS_DB: pb_s=0 -> dbcnt++. When dbcnt reaches DEBOUNCE_CYC -> HELD: pressed pulse, held=1, holdcnt=0. pb_s=1 at any point -> IDLE with dbcnt=0 and no output.
  HELD: holdcnt++. When holdcnt reaches LONG_CYC -> LONG: long_press pulse, holdcnt=0. pb_s=1 -> REL_DB with dbcnt=1; holdcnt frozen.
  LONG: pb_s=1 -> REL_DB with dbcnt=1. Otherwise behaves as described under the Optional Feature.
  REL_DB: pb_s=1 -> dbcnt++. When dbcnt reaches DEBOUNCE_CYC -> IDLE, held=0. pb_s=0 -> returns to the originating state (HELD or LONG, held in a 1-bit flag) with dbcnt=0; holdcnt resumes from its frozen value and held stays 1.
- Latency: with the first low sample of PB at edge E and PB staying low, pressed and held rise at edge E+DEBOUNCE_CYC+1. long_press rises LONG_CYC edges after pressed, with no release bounce in between. held falls DEBOUNCE_CYC+1 edges after the first high sample of PB.
- Pulse rules: pressed and long_press are single-cycle pulses and never coincide. Exactly one long_press per press.
- Bounce: a glitch of any length shorter than DEBOUNCE_CYC synchronized cycles produces no output change.
- Reset mid-operation: all outputs drop immediately. If the button is held through reset, a fresh debounce runs after reset deasserts and pressed fires again.

Optional Feature:
Macro PB_REPEAT_EN.
- Defined: in LONG, holdcnt counts and every REPEAT_CYC cycles emits a pressed pulse, then holdcnt is cleared. A release bounce freezes holdcnt, as in HELD.
- Not defined: LONG only waits for release. No further pressed pulses, holdcnt idle, and REPEAT_CYC is ignored.

Test Plan:
- Clean press: DEBOUNCE_CYC=4, LONG_CYC=20. PB low at edge 0, held low for 10 cycles -> pressed pulse and held=1 at edge 5; no long_press. PB high at edge 10 -> held=0 at edge 15.
- Press bounce: PB low 3 cycles, high 1 cycle, then low -> no pulse on the first attempt; pressed fires exactly 5 edges after the final low edge; exactly one pressed pulse in total.
- Release bounce: while held, PB high 2 cycles then low -> held stays 1, no new pressed, holdcnt resumes. Long_press arrives 2 cycles later than in the bounce-free case.
- Long press: PB low for 40 cycles -> pressed at edge 5, long_press at edge 25, nothing more without the macro. With PB_REPEAT_EN and REPEAT_CYC=6 -> additional pressed pulses at edges 31 and 37.
- Reset mid-hold: PB held low, rst_n asserted at edge 12 for 2 cycles -> all outputs 0 immediately. pressed fires again DEBOUNCE_CYC+2 edges after rst_n deasserts, the extra 2 edges being synchronizer refill.
- Glitch rejection: single-cycle low pulses on PB every 3 cycles for 50 cycles -> pressed, held and long_press stay 0 throughout.

Source files
------------

// File: rtl/pb_press_detect.sv
// pb_press_detect: press-side handler for an active-low push button.
// Synchronizes PB through two flops, debounces press and release, and reports
// a one-cycle press pulse, a debounced held level and a one-cycle long-press pulse.
// Ports: clk, rst_n (async, active-low), PB (raw, low = pressed),
//        pressed (pulse), held (level), long_press (pulse). All outputs registered.
// Optional feature: define PB_REPEAT_EN to emit auto-repeat pressed pulses every
// REPEAT_CYC cycles after long_press while the button stays down.
module pb_press_detect #(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PB,
  output logic pressed,
  output logic held,
  output logic long_press
);

  localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int DBW      = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [DBW-1:0] DB_TGT   = DBW'(DEBOUNCE_CYC);
  localparam logic [DBW-1:0] DB_ONE   = DBW'(1);
  localparam logic [HW-1:0]  LONG_TGT = HW'(LONG_CYC);
`ifdef PB_REPEAT_EN
  localparam logic [HW-1:0]  REP_TGT  = HW'(REPEAT_CYC);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    LONG     = 3'd3,
    REL_DB   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           pb_m_q, pb_m_d;
  logic           pb_s_q, pb_s_d;
  logic [DBW-1:0] dbcnt_q, dbcnt_d;
  logic [HW-1:0]  holdcnt_q, holdcnt_d;
  logic           from_long_q, from_long_d;
  logic           pressed_q, pressed_d;
  logic           held_q, held_d;
  logic           long_press_q, long_press_d;

  // Saturating increments: counters stop at their ceiling instead of wrapping.
  logic [DBW-1:0] db_inc;
  logic [HW-1:0]  hold_inc;
  logic           run_cnt;   // the button was seen down this cycle while accepted
  logic           cnt_long;  // which counting rule applies: 0 = HELD, 1 = LONG

  always_comb begin
    db_inc   = (dbcnt_q == DB_TGT) ? dbcnt_q : dbcnt_q + 1'b1;
    hold_inc = (&holdcnt_q) ? holdcnt_q : holdcnt_q + 1'b1;
  end

  always_comb begin
    pb_m_d       = PB;
    pb_s_d       = pb_m_q;
    state_d      = state_q;
    dbcnt_d      = dbcnt_q;
    holdcnt_d    = holdcnt_q;
    from_long_d  = from_long_q;
    pressed_d    = 1'b0;
    long_press_d = 1'b0;
    held_d       = held_q;
    run_cnt      = 1'b0;
    cnt_long     = 1'b0;

    case (state_q)
      IDLE: begin
        dbcnt_d = '0;
        if (!pb_s_q) begin
          if (DB_TGT == DB_ONE) begin
            state_d   = HELD;
            pressed_d = 1'b1;
            held_d    = 1'b1;
            holdcnt_d = '0;
          end else begin
            state_d = PRESS_DB;
            dbcnt_d = DB_ONE;
          end
        end
      end

      PRESS_DB: begin
        if (pb_s_q) begin
          state_d = IDLE;
          dbcnt_d = '0;
        end else if (db_inc == DB_TGT) begin
          state_d   = HELD;
          dbcnt_d   = '0;
          pressed_d = 1'b1;
          held_d    = 1'b1;
          holdcnt_d = '0;
        end else begin
          dbcnt_d = db_inc;
        end
      end

      HELD, LONG: begin
        if (pb_s_q) begin
          // Start of a possible release: holdcnt is frozen until we know.
          from_long_d = (state_q == LONG);
          if (DB_TGT == DB_ONE) begin
            state_d   = IDLE;
            held_d    = 1'b0;
            dbcnt_d   = '0;
            holdcnt_d = '0;
          end else begin
            state_d = REL_DB;
            dbcnt_d = DB_ONE;
          end
        end else begin
          run_cnt  = 1'b1;
          cnt_long = (state_q == LONG);
        end
      end

      REL_DB: begin
        if (!pb_s_q) begin
          // Release bounce: go back and resume counting on this same cycle,
          // so the hold time loses exactly the cycles the button read high.
          dbcnt_d  = '0;
          run_cnt  = 1'b1;
          cnt_long = from_long_q;
        end else if (db_inc == DB_TGT) begin
          state_d   = IDLE;
          held_d    = 1'b0;
          dbcnt_d   = '0;
          holdcnt_d = '0;
        end else begin
          dbcnt_d = db_inc;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (run_cnt) begin
      if (!cnt_long) begin
        if (hold_inc == LONG_TGT) begin
          state_d      = LONG;
          long_press_d = 1'b1;
          holdcnt_d    = '0;
        end else begin
          state_d   = HELD;
          holdcnt_d = hold_inc;
        end
      end else begin
        state_d = LONG;
`ifdef PB_REPEAT_EN
        if (hold_inc == REP_TGT) begin
          pressed_d = 1'b1;
          holdcnt_d = '0;
        end else begin
          holdcnt_d = hold_inc;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_m_q       <= 1'b1;
      pb_s_q       <= 1'b1;
      state_q      <= IDLE;
      dbcnt_q      <= '0;
      holdcnt_q    <= '0;
      from_long_q  <= 1'b0;
      pressed_q    <= 1'b0;
      held_q       <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      pb_m_q       <= pb_m_d;
      pb_s_q       <= pb_s_d;
      state_q      <= state_d;
      dbcnt_q      <= dbcnt_d;
      holdcnt_q    <= holdcnt_d;
      from_long_q  <= from_long_d;
      pressed_q    <= pressed_d;
      held_q       <= held_d;
      long_press_q <= long_press_d;
    end
  end

  assign pressed    = pressed_q;
  assign held       = held_q;
  assign long_press = long_press_q;

endmodule
